// File: rtl/decode_module.sv
// Instruction-decode stage of a five-stage MIPS-style pipeline: register file with
// write-through, control decode, branch/jump resolution, hazard stalls and ID/EX register.
module decode_module #(
   parameter int NB_BITS = 32,
   parameter int NB_JMP  = 27,
   parameter int NB_REG  = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_BITS-1:0] i_if_id_pc,
   input  logic [NB_BITS-1:0] i_if_id_instr,
   input  logic               i_wb_we,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_BITS-1:0] i_wb_data,
   input  logic               i_ex_mem_reg_we,
   input  logic [NB_REG-1:0]  i_ex_mem_rd,
   output logic [NB_BITS-1:0] o_brq_addr,
   output logic [NB_JMP-1:0]  o_jmp_addr,
   output logic               o_ctr_beq,
   output logic               o_ctr_jmp,
   output logic               o_ctr_flush,
   output logic               o_pc_we,
   output logic               o_if_id_we,
   output logic [NB_BITS-1:0] o_id_ex_rs_data,
   output logic [NB_BITS-1:0] o_id_ex_rt_data,
   output logic [NB_BITS-1:0] o_id_ex_imm,
   output logic [NB_REG-1:0]  o_id_ex_rs,
   output logic [NB_REG-1:0]  o_id_ex_rt,
   output logic [NB_REG-1:0]  o_id_ex_rd,
   output logic [9:0]         o_id_ex_ctrl
);

   localparam int NB_REGS = 1 << NB_REG;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALU operation codes carried to EX; R-type defers to the funct field there.
   localparam logic [3:0] ALU_NONE  = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_SUB   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_AND   = 4'b0100;
   localparam logic [3:0] ALU_OR    = 4'b0101;
   localparam logic [3:0] ALU_LUI   = 4'b0110;
   localparam logic [3:0] ALU_RTYPE = 4'b1000;

   localparam logic [1:0] IMM_SIGN = 2'd0;
   localparam logic [1:0] IMM_ZERO = 2'd1;
   localparam logic [1:0] IMM_LUI  = 2'd2;

   function automatic logic [NB_BITS-1:0] sign_ext(input logic [15:0] value);
      return {{(NB_BITS-16){value[15]}}, value};
   endfunction

   function automatic logic [NB_BITS-1:0] zero_ext(input logic [15:0] value);
      return {{(NB_BITS-16){1'b0}}, value};
   endfunction

   logic [NB_BITS-1:0] reg_file_r [NB_REGS];

   logic [5:0]         opcode_s;
   logic [NB_REG-1:0]  rs_s;
   logic [NB_REG-1:0]  rt_s;
   logic [NB_REG-1:0]  rd_s;
   logic [15:0]        imm_s;

   logic               reg_we_s;
   logic               mem_read_s;
   logic               mem_write_s;
   logic               mem_to_reg_s;
   logic               alu_src_s;
   logic [3:0]         alu_op_s;
   logic               dst_rd_s;
   logic               rt_src_s;
   logic               is_beq_s;
   logic               is_bne_s;
   logic               is_jmp_s;
   logic [1:0]         imm_sel_s;

   logic [NB_BITS-1:0] ext_imm_s;
   logic [NB_REG-1:0]  dst_s;
   logic [NB_BITS-1:0] rs_data_s;
   logic [NB_BITS-1:0] rt_data_s;
   logic [9:0]         ctrl_s;

   logic               load_use_s;
   logic               idex_match_s;
   logic               exmem_match_s;
   logic               branch_haz_s;
   logic               hazard_s;
   logic               taken_s;

   assign opcode_s = i_if_id_instr[31:26];
   assign rs_s     = i_if_id_instr[21 +: NB_REG];
   assign rt_s     = i_if_id_instr[16 +: NB_REG];
   assign rd_s     = i_if_id_instr[11 +: NB_REG];
   assign imm_s    = i_if_id_instr[15:0];

   // Opcode decode into control fields; unknown opcodes leave everything at zero.
   always_comb begin
      reg_we_s     = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_s    = 1'b0;
      alu_op_s     = ALU_NONE;
      dst_rd_s     = 1'b0;
      rt_src_s     = 1'b0;
      is_beq_s     = 1'b0;
      is_bne_s     = 1'b0;
      is_jmp_s     = 1'b0;
      imm_sel_s    = IMM_SIGN;
      case (opcode_s)
         OP_RTYPE: begin
            reg_we_s = 1'b1;
            alu_op_s = ALU_RTYPE;
            dst_rd_s = 1'b1;
            rt_src_s = 1'b1;
         end
         OP_LW: begin
            reg_we_s     = 1'b1;
            mem_read_s   = 1'b1;
            mem_to_reg_s = 1'b1;
            alu_src_s    = 1'b1;
            alu_op_s     = ALU_ADD;
         end
         OP_SW: begin
            mem_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_op_s    = ALU_ADD;
            rt_src_s    = 1'b1;
         end
         OP_BEQ: begin
            alu_op_s = ALU_SUB;
            rt_src_s = 1'b1;
            is_beq_s = 1'b1;
         end
         OP_BNE: begin
            alu_op_s = ALU_SUB;
            rt_src_s = 1'b1;
            is_bne_s = 1'b1;
         end
         OP_J: begin
            is_jmp_s = 1'b1;
         end
         OP_ADDI: begin
            reg_we_s  = 1'b1;
            alu_src_s = 1'b1;
            alu_op_s  = ALU_ADD;
         end
         OP_SLTI: begin
            reg_we_s  = 1'b1;
            alu_src_s = 1'b1;
            alu_op_s  = ALU_SLT;
         end
         OP_ANDI: begin
            reg_we_s  = 1'b1;
            alu_src_s = 1'b1;
            alu_op_s  = ALU_AND;
            imm_sel_s = IMM_ZERO;
         end
         OP_ORI: begin
            reg_we_s  = 1'b1;
            alu_src_s = 1'b1;
            alu_op_s  = ALU_OR;
            imm_sel_s = IMM_ZERO;
         end
         OP_LUI: begin
            reg_we_s  = 1'b1;
            alu_src_s = 1'b1;
            alu_op_s  = ALU_LUI;
            imm_sel_s = IMM_LUI;
         end
         default: begin
            reg_we_s = 1'b0;
         end
      endcase
   end

   // Immediate extension and destination selection.
   always_comb begin
      ext_imm_s = sign_ext(imm_s);
      dst_s     = '0;
      case (imm_sel_s)
         IMM_ZERO: ext_imm_s = zero_ext(imm_s);
         IMM_LUI:  ext_imm_s = zero_ext(imm_s) << 16;
         default:  ext_imm_s = sign_ext(imm_s);
      endcase
      if (!reg_we_s) begin
         dst_s = '0;
      end else if (dst_rd_s) begin
         dst_s = rd_s;
      end else begin
         dst_s = rt_s;
      end
   end

   // Register reads; a same-cycle writeback is forwarded so branches see fresh data.
   always_comb begin
      rs_data_s = '0;
      rt_data_s = '0;
      if (rs_s == '0) begin
         rs_data_s = '0;
      end else if (i_wb_we && (i_wb_addr == rs_s)) begin
         rs_data_s = i_wb_data;
      end else begin
         rs_data_s = reg_file_r[rs_s];
      end
      if (rt_s == '0) begin
         rt_data_s = '0;
      end else if (i_wb_we && (i_wb_addr == rt_s)) begin
         rt_data_s = i_wb_data;
      end else begin
         rt_data_s = reg_file_r[rt_s];
      end
   end

   assign ctrl_s = {reg_we_s, mem_read_s, mem_write_s, mem_to_reg_s, alu_src_s, alu_op_s, 1'b0};

   // Branches resolve in ID, so any in-flight producer of a compared register must stall them.
   assign load_use_s    = o_id_ex_ctrl[8] && (o_id_ex_rt != '0) &&
                          ((o_id_ex_rt == rs_s) || (rt_src_s && (o_id_ex_rt == rt_s)));
   assign idex_match_s  = o_id_ex_ctrl[9] && (o_id_ex_rd != '0) &&
                          ((o_id_ex_rd == rs_s) || (o_id_ex_rd == rt_s));
   assign exmem_match_s = i_ex_mem_reg_we && (i_ex_mem_rd != '0) &&
                          ((i_ex_mem_rd == rs_s) || (i_ex_mem_rd == rt_s));
   assign branch_haz_s  = (is_beq_s || is_bne_s) && (idex_match_s || exmem_match_s);
   assign hazard_s      = load_use_s || branch_haz_s;
   assign taken_s       = (is_beq_s && (rs_data_s == rt_data_s)) ||
                          (is_bne_s && (rs_data_s != rt_data_s));

   // Pipeline control; a stall suppresses any redirect until the branch is re-evaluated.
   always_comb begin
      o_pc_we    = 1'b1;
      o_if_id_we = 1'b1;
      o_ctr_beq  = 1'b0;
      o_ctr_jmp  = 1'b0;
      if (hazard_s) begin
         o_pc_we    = 1'b0;
         o_if_id_we = 1'b0;
      end else begin
         o_ctr_beq = taken_s;
         o_ctr_jmp = is_jmp_s;
      end
   end

   assign o_ctr_flush = o_ctr_beq | o_ctr_jmp;
   assign o_brq_addr  = i_if_id_pc + (sign_ext(imm_s) << 2);
   assign o_jmp_addr  = {i_if_id_instr[NB_JMP-3:0], 2'b00};

   // Register file; r0 is never written.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NB_REGS; i++) begin
            reg_file_r[i] <= '0;
         end
      end else if (i_wb_we && (i_wb_addr != '0)) begin
         reg_file_r[i_wb_addr] <= i_wb_data;
      end
   end

   // ID/EX pipeline register; a hazard loads an all-zero bubble.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_id_ex_rs_data <= '0;
         o_id_ex_rt_data <= '0;
         o_id_ex_imm     <= '0;
         o_id_ex_rs      <= '0;
         o_id_ex_rt      <= '0;
         o_id_ex_rd      <= '0;
         o_id_ex_ctrl    <= '0;
      end else if (hazard_s) begin
         o_id_ex_rs_data <= '0;
         o_id_ex_rt_data <= '0;
         o_id_ex_imm     <= '0;
         o_id_ex_rs      <= '0;
         o_id_ex_rt      <= '0;
         o_id_ex_rd      <= '0;
         o_id_ex_ctrl    <= '0;
      end else begin
         o_id_ex_rs_data <= rs_data_s;
         o_id_ex_rt_data <= rt_data_s;
         o_id_ex_imm     <= ext_imm_s;
         o_id_ex_rs      <= rs_s;
         o_id_ex_rt      <= rt_s;
         o_id_ex_rd      <= dst_s;
         o_id_ex_ctrl    <= ctrl_s;
      end
   end

endmodule

// File: doc/decode_module.md
DECODE_MODULE -- requirements
Module: decode_module

Interface
REQ-001 SHALL have parameter NB_BITS, default 32, datapath width.
REQ-002 SHALL have parameter NB_JMP, default 27, jump-target width.
REQ-003 SHALL have parameter NB_REG, default 5, register-address width (32 registers).
REQ-004 SHALL have one clock; reset is asynchronous and active-high (ports i_clk, i_rst).
REQ-005 SHALL have ports, one per line:
i_clk  in  1  clock
i_rst  in  1  async active-high reset
i_if_id_pc  in  NB_BITS  PC+4 of instruction in IF/ID
i_if_id_instr  in  NB_BITS  instruction in IF/ID
i_wb_we  in  1  writeback register write enable
i_wb_addr  in  NB_REG  writeback destination
i_wb_data  in  NB_BITS  writeback data
i_ex_mem_reg_we  in  1  EX/MEM stage writes a register
i_ex_mem_rd  in  NB_REG  EX/MEM destination
o_brq_addr  out  NB_BITS  branch target
o_jmp_addr  out  NB_JMP  jump target
o_ctr_beq  out  1  branch taken
o_ctr_jmp  out  1  jump taken
o_ctr_flush  out  1  squash IF/ID
o_pc_we  out  1  PC write enable
o_if_id_we  out  1  IF/ID write enable
o_id_ex_rs_data  out  NB_BITS  registered rs value
o_id_ex_rt_data  out  NB_BITS  registered rt value
o_id_ex_imm  out  NB_BITS  registered extended immediate
o_id_ex_rs  out  NB_REG  registered rs address
o_id_ex_rt  out  NB_REG  registered rt address
o_id_ex_rd  out  NB_REG  registered destination (rd or rt per reg_dst)
o_id_ex_ctrl  out  10  registered control {reg_we, mem_read, mem_write, mem_to_reg, alu_src, alu_op[3:0], link=0}

Function
REQ-006 SHALL hold a 32x NB_BITS register file; register 0 reads 0 always, writes to it ignored.
REQ-007 SHALL write i_wb_data at posedge i_clk when i_wb_we; a same-cycle read of i_wb_addr (nonzero) SHALL return i_wb_data (write-through bypass).
REQ-008 SHALL decode opcode: 0x00 R-type, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J, 0x08 ADDI, 0x0A SLTI, 0x0C ANDI, 0x0D ORI, 0x0F LUI; any other opcode decodes as NOP (all control 0).
REQ-009 SHALL sign-extend imm[15:0] except ANDI/ORI (zero-extend) and LUI ({imm,16'h0}).
REQ-010 SHALL select destination rd for R-type, rt for ADDI/SLTI/ANDI/ORI/LUI/LW; SW/BEQ/BNE/J have reg_we=0.
REQ-011 SHALL compute o_brq_addr = i_if_id_pc + (sign_ext(imm) << 2), modulo 2^NB_BITS, combinationally.
REQ-012 SHALL compute o_jmp_addr = {instr[24:0], 2'b00}.
REQ-013 SHALL assert o_ctr_beq for BEQ when rs==rt, BNE when rs!=rt, using bypassed register values; o_ctr_jmp for J; o_ctr_flush = o_ctr_beq | o_ctr_jmp.
REQ-014 SHALL detect load-use: o_id_ex_ctrl.mem_read=1 and o_id_ex_rt nonzero equals current rs, or equals current rt when rt is a source (R-type, SW, BEQ, BNE).
REQ-015 SHALL detect branch hazard: current BEQ/BNE and (ID/EX reg_we with o_id_ex_rd nonzero, or i_ex_mem_reg_we with i_ex_mem_rd nonzero) matching rs or rt.
REQ-016 On any hazard SHALL drive o_pc_we=0, o_if_id_we=0, o_ctr_beq=o_ctr_jmp=o_ctr_flush=0, and load ID/EX with a bubble (all fields 0); otherwise o_pc_we=o_if_id_we=1.
REQ-017 ID/EX registers SHALL update every posedge i_clk (1-cycle latency); no other enable.
REQ-018 Hazard and taken-branch in the same cycle: stall wins; branch re-evaluated next cycle.

Reset
REQ-019 i_rst=1 SHALL asynchronously clear all ID/EX outputs and all 32 registers to 0; combinational outputs follow from cleared state (o_pc_we=o_if_id_we=1 with NOP in IF/ID).
REQ-020 Reset released mid-stall SHALL leave no pending bubble; first post-reset cycle decodes normally.

Verification
REQ-021 WB writes r1=5, same cycle ADDI r2,r1,3 decoded -> o_id_ex_rs_data=5, o_id_ex_imm=3, o_id_ex_rd=2 next cycle.
REQ-022 LW r3 in ID/EX, ADD r4,r3,r1 in IF/ID -> o_pc_we=0, o_if_id_we=0 one cycle, ID/EX ctrl=0; next cycle normal.
REQ-023 r1=r2=7, BEQ r1,r2,-1 at PC+4=0x10 -> o_ctr_beq=1, o_ctr_flush=1, o_brq_addr=0x0C.
REQ-024 J 0x0000040 -> o_ctr_jmp=1, o_jmp_addr=0x100; ORI imm 0xFFFF -> o_id_ex_imm=0x0000FFFF.
REQ-025 Write r0=9 then read r0 -> 0; assert i_rst mid-operation -> all ID/EX outputs 0 immediately, without clock edge.
